// File: rtl/alu_arbiter.sv
// Two-port request/response arbiter in front of one shared ALU32Bit.
// Define ALU_ARB_RR_EN for round-robin; default build is fixed priority (port 0).
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqValid0,
  output logic             ReqReady0,
  input  logic [OPW-1:0]   ReqOp0,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic             ReqValid1,
  output logic             ReqReady1,
  input  logic [OPW-1:0]   ReqOp1,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB1,
  output logic             RespValid0,
  input  logic             RespReady0,
  output logic [WIDTH-1:0] RespResult0,
  output logic             RespZero0,
  output logic             RespValid1,
  input  logic             RespReady1,
  output logic [WIDTH-1:0] RespResult1,
  output logic             RespZero1,
  output logic [OPW-1:0]   ALUControl,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] ALUResult,
  input  logic             Zero
);

  logic elig0, elig1;
  logic gnt0, gnt1;

  // A buffer being drained this cycle can be refilled in the same cycle.
  assign elig0 = !Reset && ReqValid0 && (!RespValid0 || RespReady0);
  assign elig1 = !Reset && ReqValid1 && (!RespValid1 || RespReady1);

`ifdef ALU_ARB_RR_EN
  logic prio;

  assign gnt0 = elig0 && (!elig1 || !prio);
  assign gnt1 = elig1 && (!elig0 || prio);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      prio <= 1'b0;
    end else if (gnt0) begin
      prio <= 1'b1;
    end else if (gnt1) begin
      prio <= 1'b0;
    end
  end
`else
  assign gnt0 = elig0;
  assign gnt1 = elig1 && !elig0;
`endif

  assign ReqReady0 = gnt0;
  assign ReqReady1 = gnt1;

  always_comb begin
    ALUControl = '0;
    A          = '0;
    B          = '0;
    unique case (1'b1)
      gnt0: begin
        ALUControl = ReqOp0;
        A          = ReqA0;
        B          = ReqB0;
      end
      gnt1: begin
        ALUControl = ReqOp1;
        A          = ReqA1;
        B          = ReqB1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RespValid0  <= 1'b0;
      RespResult0 <= '0;
      RespZero0   <= 1'b0;
    end else if (gnt0) begin
      RespValid0  <= 1'b1;
      RespResult0 <= ALUResult;
      RespZero0   <= Zero;
    end else if (RespValid0 && RespReady0) begin
      RespValid0  <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RespValid1  <= 1'b0;
      RespResult1 <= '0;
      RespZero1   <= 1'b0;
    end else if (gnt1) begin
      RespValid1  <= 1'b1;
      RespResult1 <= ALUResult;
      RespZero1   <= Zero;
    end else if (RespValid1 && RespReady1) begin
      RespValid1  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU32Bit model.
// Contention expectations follow ALU_ARB_RR_EN when it is defined.
module tb_alu_arbiter;

  localparam int W = 32;
  localparam int O = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         ReqValid0, ReqValid1;
  logic         ReqReady0, ReqReady1;
  logic [O-1:0] ReqOp0, ReqOp1;
  logic [W-1:0] ReqA0, ReqB0, ReqA1, ReqB1;
  logic         RespValid0, RespValid1;
  logic         RespReady0, RespReady1;
  logic [W-1:0] RespResult0, RespResult1;
  logic         RespZero0, RespZero1;
  logic [O-1:0] ALUControl;
  logic [W-1:0] A, B;
  logic [W-1:0] ALUResult;
  logic         Zero;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  alu_arbiter #(.WIDTH(W), .OPW(O)) dut (
    .Clk(Clk), .Reset(Reset),
    .ReqValid0(ReqValid0), .ReqReady0(ReqReady0),
    .ReqOp0(ReqOp0), .ReqA0(ReqA0), .ReqB0(ReqB0),
    .ReqValid1(ReqValid1), .ReqReady1(ReqReady1),
    .ReqOp1(ReqOp1), .ReqA1(ReqA1), .ReqB1(ReqB1),
    .RespValid0(RespValid0), .RespReady0(RespReady0),
    .RespResult0(RespResult0), .RespZero0(RespZero0),
    .RespValid1(RespValid1), .RespReady1(RespReady1),
    .RespResult1(RespResult1), .RespZero1(RespZero1),
    .ALUControl(ALUControl), .A(A), .B(B),
    .ALUResult(ALUResult), .Zero(Zero)
  );

  // Shared ALU model
  always_comb begin
    ALUResult = '0;
    case (ALUControl)
      4'b0000: ALUResult = A & B;
      4'b0001: ALUResult = A | B;
      4'b0010: ALUResult = A + B;
      4'b0110: ALUResult = A - B;
      4'b0111: ALUResult = {31'd0, $signed(A) < $signed(B)};
      default: ALUResult = '0;
    endcase
    Zero = (ALUResult == '0);
  end

  typedef struct {
    logic         rst, v0, v1, rr0, rr1;
    logic [O-1:0] op0, op1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         rdy0, rdy1, rv0, rv1, z0, z1;
    logic [W-1:0] res0, res1;
    logic [O-1:0] ctl;
    logic [W-1:0] ea, eb;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1,
                       input logic rr0, input logic rr1,
                       input logic [O-1:0] op0, input logic [W-1:0] a0,
                       input logic [W-1:0] b0, input logic [O-1:0] op1,
                       input logic [W-1:0] a1, input logic [W-1:0] b1);
    Reset = rst; ReqValid0 = v0; ReqValid1 = v1;
    RespReady0 = rr0; RespReady1 = rr1;
    ReqOp0 = op0; ReqA0 = a0; ReqB0 = b0;
    ReqOp1 = op1; ReqA1 = a1; ReqB1 = b1;
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_row(input int i, input logic rst, input logic v0,
                         input logic v1, input logic rr0, input logic rr1,
                         input logic [O-1:0] op0, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input logic [O-1:0] op1,
                         input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic rdy0, input logic rdy1,
                         input logic rv0, input logic [W-1:0] res0,
                         input logic z0, input logic rv1,
                         input logic [W-1:0] res1, input logic z1,
                         input logic [O-1:0] ctl, input logic [W-1:0] ea,
                         input logic [W-1:0] eb);
    tbl[i].rst = rst; tbl[i].v0 = v0; tbl[i].v1 = v1;
    tbl[i].rr0 = rr0; tbl[i].rr1 = rr1;
    tbl[i].op0 = op0; tbl[i].a0 = a0; tbl[i].b0 = b0;
    tbl[i].op1 = op1; tbl[i].a1 = a1; tbl[i].b1 = b1;
    tbl[i].rdy0 = rdy0; tbl[i].rdy1 = rdy1;
    tbl[i].rv0 = rv0; tbl[i].res0 = res0; tbl[i].z0 = z0;
    tbl[i].rv1 = rv1; tbl[i].res1 = res1; tbl[i].z1 = z1;
    tbl[i].ctl = ctl; tbl[i].ea = ea; tbl[i].eb = eb;
  endtask

  initial begin
    logic rr_en;
`ifdef ALU_ARB_RR_EN
    rr_en = 1'b1;
`else
    rr_en = 1'b0;
`endif
    // row: rst v0 v1 rr0 rr1 | op0 a0 b0 | op1 a1 b1 |
    //      rdy0 rdy1 | rv0 res0 z0 | rv1 res1 z1 | ctl a b
    set_row(0, 1, 1, 1, 1, 1, 4'h2, 5, 7, 4'h1, 3, 4,
            0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    set_row(1, 0, 0, 0, 1, 1, 4'h0, 0, 0, 4'h0, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0);
    set_row(2, 0, 1, 0, 1, 1, 4'h2, 5, 7, 4'h0, 0, 0,
            1, 0, 0, 0, 0, 0, 0, 0, 4'h2, 5, 7);
    set_row(3, 0, 0, 0, 1, 1, 4'h0, 0, 0, 4'h0, 0, 0,
            0, 0, 1, 12, 0, 0, 0, 0, 4'h0, 0, 0);
    set_row(4, 0, 0, 0, 1, 1, 4'h0, 0, 0, 4'h0, 0, 0,
            0, 0, 0, 12, 0, 0, 0, 0, 4'h0, 0, 0);
    set_row(5, 0, 0, 1, 1, 0, 4'h0, 0, 0, 4'h6, 9, 9,
            0, 1, 0, 12, 0, 0, 0, 0, 4'h6, 9, 9);
    set_row(6, 0, 0, 1, 1, 0, 4'h0, 0, 0, 4'h1, 3, 4,
            0, 0, 0, 12, 0, 1, 0, 1, 4'h0, 0, 0);
    set_row(7, 0, 0, 1, 1, 1, 4'h0, 0, 0, 4'h1, 3, 4,
            0, 1, 0, 12, 0, 1, 0, 1, 4'h1, 3, 4);
    set_row(8, 0, 0, 0, 1, 1, 4'h0, 0, 0, 4'h0, 0, 0,
            0, 0, 0, 12, 0, 1, 7, 0, 4'h0, 0, 0);
    set_row(9, 0, 0, 0, 1, 1, 4'h0, 0, 0, 4'h0, 0, 0,
            0, 0, 0, 12, 0, 0, 7, 0, 4'h0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rst, tbl[i].v0, tbl[i].v1, tbl[i].rr0, tbl[i].rr1,
            tbl[i].op0, tbl[i].a0, tbl[i].b0,
            tbl[i].op1, tbl[i].a1, tbl[i].b1);
      @(negedge Clk);
      check($sformatf("row%0d ready", i),
            {ReqReady0, ReqReady1}, {tbl[i].rdy0, tbl[i].rdy1});
      check($sformatf("row%0d resp0", i),
            {RespValid0, RespZero0, RespResult0},
            {tbl[i].rv0, tbl[i].z0, tbl[i].res0});
      check($sformatf("row%0d resp1", i),
            {RespValid1, RespZero1, RespResult1},
            {tbl[i].rv1, tbl[i].z1, tbl[i].res1});
      check($sformatf("row%0d alu", i), {ALUControl, A, B},
            {tbl[i].ctl, tbl[i].ea, tbl[i].eb});
      tick();
    end

    // Contention: port 0 SUB 9-9, port 1 OR F0|0F
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 6; k++) begin
      logic er0, er1, ev0, ev1;
      drive(0, 1, 1, 1, 1, 4'h6, 9, 9, 4'h1, 32'hF0, 32'h0F);
      if (rr_en) begin
        er0 = (k % 2 == 0);
        er1 = (k % 2 == 1);
        ev0 = (k % 2 == 1);
        ev1 = (k >= 2) && (k % 2 == 0);
      end else begin
        er0 = 1'b1;
        er1 = 1'b0;
        ev0 = (k >= 1);
        ev1 = 1'b0;
      end
      @(negedge Clk);
      check($sformatf("cont%0d ready", k),
            {ReqReady0, ReqReady1}, {er0, er1});
      check($sformatf("cont%0d valid", k),
            {RespValid0, RespValid1}, {ev0, ev1});
      if (ev0)
        check($sformatf("cont%0d res0", k),
              {RespZero0, RespResult0}, {1'b1, 32'd0});
      if (ev1)
        check($sformatf("cont%0d res1", k),
              {RespZero1, RespResult1}, {1'b0, 32'hFF});
      tick();
    end

    // Backpressure on port 0
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 0, 0, 1, 4'h2, 5, 7, 0, 0, 0);
    @(negedge Clk);
    check("bp load", {ReqReady0, ReqReady1}, 2'b10);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 1, 0, 1, 4'h2, 1, 1, 4'h1, 32'hF0, 32'h0F);
      @(negedge Clk);
      check($sformatf("bp%0d ready", k), {ReqReady0, ReqReady1}, 2'b01);
      check($sformatf("bp%0d hold0", k), {RespValid0, RespResult0},
            {1'b1, 32'd12});
      if (k >= 1)
        check($sformatf("bp%0d res1", k), {RespValid1, RespResult1},
              {1'b1, 32'hFF});
      tick();
    end
    drive(0, 1, 1, 1, 1, 4'h2, 1, 1, 4'h1, 32'hF0, 32'h0F);
    @(negedge Clk);
    check("refill ready", {ReqReady0, ReqReady1}, 2'b10);
    check("refill alu", {ALUControl, A, B}, {4'h2, 32'd1, 32'd1});
    tick();
    drive(0, 1, 1, 0, 0, 4'h2, 1, 1, 4'h1, 32'hF0, 32'h0F);
    @(negedge Clk);
    check("refill res0", {RespValid0, RespResult0}, {1'b1, 32'd2});
    check("fill1 ready", {ReqReady0, ReqReady1}, 2'b01);
    tick();

    // Reset mid-stream with both buffers full
    drive(1, 1, 1, 0, 0, 4'h2, 1, 1, 4'h1, 32'hF0, 32'h0F);
    @(negedge Clk);
    check("full pre-rst", {RespValid0, RespValid1}, 2'b11);
    check("rst ready", {ReqReady0, ReqReady1}, 2'b00);
    check("rst alu", {ALUControl, A, B}, '0);
    tick();
    drive(0, 1, 1, 1, 1, 4'h2, 1, 1, 4'h1, 32'hF0, 32'h0F);
    @(negedge Clk);
    check("post-rst valid", {RespValid0, RespValid1}, 2'b00);
    check("post-rst data", {RespZero0, RespResult0, RespZero1, RespResult1},
          '0);
    check("post-rst grant", {ReqReady0, ReqReady1}, 2'b10);
    tick();
    @(negedge Clk);
    check("post-rst grant2", {ReqReady0, ReqReady1},
          rr_en ? 2'b01 : 2'b10);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one ALU32Bit instance between two requesters, e.g. the execute stage (port 0) and an address/branch helper (port 1). The block arbitrates request/response handshakes and drives the shared ALU's `ALUControl`, `A` and `B` inputs combinationally from the granted request. It captures `ALUResult`/`Zero` into a one-entry response buffer per port. Sustained throughput is one ALU operation per cycle across both ports, and latency is one cycle from acceptance to response.

## Interface
Parameters:
- `WIDTH`, default 32: operand/result width; must match the ALU.
- `OPW`, default 4: ALUControl width.

Ports:
- `Clk`, in, 1: rising-edge clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `ReqValid0` / `ReqValid1`, in, 1: request present on port 0 / 1.
- `ReqReady0` / `ReqReady1`, out, 1: request accepted this cycle when asserted together with the matching `ReqValid`.
- `ReqOp0` / `ReqOp1`, in, OPW: ALUControl code.
- `ReqA0`, `ReqB0` / `ReqA1`, `ReqB1`, in, WIDTH: operands.
- `RespValid0` / `RespValid1`, out, 1: response buffer holds a result.
- `RespReady0` / `RespReady1`, in, 1: consumer takes the response this cycle.
- `RespResult0` / `RespResult1`, out, WIDTH: captured `ALUResult`.
- `RespZero0` / `RespZero1`, out, 1: captured `Zero`.
- `ALUControl`, out, OPW: to the shared ALU.
- `A`, `B`, out, WIDTH: to the shared ALU.
- `ALUResult`, in, WIDTH: from the shared ALU (combinational).
- `Zero`, in, 1: from the shared ALU.

## Operation
- Port p is eligible when `ReqValid_p`=1 and its buffer is free. A buffer is free when `RespValid_p`=0, or when `RespValid_p`=1 and `RespReady_p`=1 in the same cycle (drain-and-refill allowed).
- At most one grant per cycle. `ReqReady_p` is 1 only for the granted port. `ReqReady_p` may depend combinationally on `ReqValid`, `RespValid` and `RespReady`.
- Arbitration:
  - If one port is eligible, it wins regardless of priority.
  - If both are eligible, the port named by the priority pointer `Prio` wins.
  - After any grant to port p, `Prio` becomes 1-p. With no grant, `Prio` holds.
- Datapath:
  - With a grant, `ALUControl`/`A`/`B` equal the granted port's `ReqOp`/`ReqA`/`ReqB`.
  - With no grant, they are driven to all zeros.
- Capture: on the clock edge ending a grant cycle, `RespResult_p`←`ALUResult` and `RespZero_p`←`Zero`; `RespValid_p`←1.
- Drain: if `RespValid_p`&&`RespReady_p` and no new grant to p, `RespValid_p`←0. `RespResult_p`/`RespZero_p` hold their last values.
- A full, undrained buffer blocks only its own port. The other port continues at full rate.
- Opcodes are passed through unchecked. Undefined codes yield whatever the ALU produces.

## Timing
- Reset (synchronous, active-high):
  - `RespValid0`/`RespValid1`=0, `RespResult0`/`RespResult1`=0, `RespZero0`/`RespZero1`=0.
  - `Prio`=0.
  - `ReqReady0`/`ReqReady1` are forced to 0 while `Reset`=1. No request is accepted in a reset cycle.
  - `ALUControl`/`A`/`B`=0.
- Latency: a request accepted in cycle N shows `RespValid_p`=1 in cycle N+1 with its result.
- Back-to-back on one port: one request per cycle when the consumer holds `RespReady_p`=1.
- Both ports streaming with consumers ready: grants alternate 0,1,0,1…, and each port gets 50% throughput.
- Reset mid-operation: buffered, undrained responses are discarded; the results are lost and no `RespValid` appears after reset.
- Response ordering per port is strictly in order, trivially so because there is a single buffer entry.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin arbitration with `Prio` as described.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins when both are eligible. `Prio` is not implemented, so port 1 can starve under continuous port-0 traffic.

## Test plan
- Reset then idle: both ports quiet → all outputs 0, `ReqReady0`/`ReqReady1`=0 during reset, and `RespValid` stays 0 afterwards.
- Single op: port 0 sends op=0010, A=5, B=7 with `RespReady0`=1 → `ReqReady0`=1 in cycle N; cycle N+1 shows `RespValid0`=1, `RespResult0`=12, `RespZero0`=0.
- Contention with `ALU_ARB_RR_EN`: both ports request continuously, port 0 with SUB 9-9 and port 1 with OR 0xF0|0x0F → grants alternate 0,1,0,1; port 0 returns 0 with Zero=1, port 1 returns 0xFF with Zero=0.
- Contention without `ALU_ARB_RR_EN`: same stimulus as above → port 0 is granted every cycle and `ReqReady1` stays 0.
- Backpressure: `RespReady0`=0 with `RespValid0`=1 while both ports request → `ReqReady0`=0, port 1 is granted each cycle, and `RespResult0` holds its value. Raising `RespReady0` produces a drain-and-refill in the same cycle.
- Reset mid-stream: assert `Reset` for one cycle while both buffers are full and both ports are requesting → next cycle `RespValid0`/`RespValid1`=0 and `Prio`=0. The first grant after reset goes to port 0 when both request.
